// File: rtl/hazard_forward_unit_pkg.sv
// Shared types and helpers for the hazard/forwarding unit: producer records
// and the saturating Tnew decrement applied as records age through the pipe.
package hazard_pkg;

   localparam int AW = 5;
   localparam int DW = 32;
   localparam int TW = 2;

   localparam logic [AW-1:0] REG_ZERO  = '0;
   localparam logic [TW-1:0] TNEW_NONE = '0;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [TW-1:0] t;
      logic [DW-1:0] v;
   } prod_rec_t;

   // A record that already holds its value stays at zero as it moves on.
   function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] t);
      return (t == TNEW_NONE) ? TNEW_NONE : t - TW'(1);
   endfunction

endpackage

// File: rtl/hazard_forward_unit_if.sv
// Bundle of RR/EX/DM producer-consumer signals between the core and the
// hazard/forwarding unit; master is the core side, slave the unit.
interface hazard_forward_unit_if
   import hazard_pkg::*;
#(
   parameter int CNTW = 32
);
   logic [AW-1:0]   rr_ause0_i;
   logic [AW-1:0]   rr_ause1_i;
   logic [TW-1:0]   rr_tuse0_i;
   logic [TW-1:0]   rr_tuse1_i;
   logic [DW-1:0]   rr_v0_i;
   logic [DW-1:0]   rr_v1_i;
   logic [AW-1:0]   rr_anew_i;
   logic [TW-1:0]   rr_tnew_i;
   logic [DW-1:0]   rr_vnew_i;
   logic [DW-1:0]   ex_vnew_i;
   logic            ex_we_i;
   logic [DW-1:0]   dm_vnew_i;
   logic            dm_we_i;
   logic [DW-1:0]   ex_raw0_i;
   logic [DW-1:0]   ex_raw1_i;
   logic            stall_o;
   logic [DW-1:0]   rr_opnd0_o;
   logic [DW-1:0]   rr_opnd1_o;
   logic [DW-1:0]   ex_opnd0_o;
   logic [DW-1:0]   ex_opnd1_o;
   logic [CNTW-1:0] stall_cnt_o;

   modport master (
      output rr_ause0_i, rr_ause1_i, rr_tuse0_i, rr_tuse1_i, rr_v0_i, rr_v1_i,
             rr_anew_i, rr_tnew_i, rr_vnew_i, ex_vnew_i, ex_we_i,
             dm_vnew_i, dm_we_i, ex_raw0_i, ex_raw1_i,
      input  stall_o, rr_opnd0_o, rr_opnd1_o, ex_opnd0_o, ex_opnd1_o, stall_cnt_o
   );

   modport slave (
      input  rr_ause0_i, rr_ause1_i, rr_tuse0_i, rr_tuse1_i, rr_v0_i, rr_v1_i,
             rr_anew_i, rr_tnew_i, rr_vnew_i, ex_vnew_i, ex_we_i,
             dm_vnew_i, dm_we_i, ex_raw0_i, ex_raw1_i,
      output stall_o, rr_opnd0_o, rr_opnd1_o, ex_opnd0_o, ex_opnd1_o, stall_cnt_o
   );

endinterface

// File: rtl/hazard_forward_unit_fwd_select.sv
// Priority match of one source register against N producer records; index 0
// has the highest priority and only the first matching record is reported.
module fwd_select
   import hazard_pkg::*;
#(
   parameter int N = 3
) (
   input  prod_rec_t     recs_i [N],
   input  logic [AW-1:0] addr_i,
   input  logic [DW-1:0] fallback_i,
   output logic          hit_o,
   output logic          ready_o,
   output logic [DW-1:0] value_o
);

   // Walk from lowest to highest priority so the highest-priority match wins.
   always_comb begin
      hit_o   = 1'b0;
      ready_o = 1'b0;
      value_o = fallback_i;
      for (int k = N - 1; k >= 0; k--) begin
         if (addr_i != REG_ZERO && recs_i[k].a == addr_i) begin
            hit_o   = 1'b1;
            ready_o = (recs_i[k].t == TNEW_NONE);
            value_o = recs_i[k].v;
         end
      end
   end

endmodule

// File: rtl/hazard_forward_unit.sv
// Producer scoreboard for EX/DM/RW, RR-stage stall decision and operand
// forwarding at RR and EX for the 5-stage MIPS core.
module hazard_forward_unit
   import hazard_pkg::*;
#(
   parameter int CNTW = 32
) (
   input logic                  clk,
   input logic                  reset,
   hazard_forward_unit_if.slave bus
);

   prod_rec_t       exEntry_q, dmEntry_q, rwEntry_q;
   prod_rec_t       exEntry_d, dmEntry_d, rwEntry_d;
   prod_rec_t       exEff, dmEff, rwEff;
   prod_rec_t       rrRecs [3];
   prod_rec_t       exRecs [2];
   logic [AW-1:0]   exSrc0_q, exSrc1_q, exSrc0_d, exSrc1_d;
   logic [CNTW-1:0] stallCnt_q, stallCnt_d;
   logic            stall;
   logic [3:0]      selHit, selReady;
   logic [DW-1:0]   selValue [4];

   function automatic logic late(input prod_rec_t r, input logic [AW-1:0] src,
                                 input logic [TW-1:0] tuse);
      return (src != REG_ZERO) && (r.a == src) && (r.t > tuse);
   endfunction

   // A result written back in EX/DM this cycle counts as already available.
   always_comb begin
      exEff   = exEntry_q;
      dmEff   = dmEntry_q;
      rwEff   = rwEntry_q;
      rwEff.t = TNEW_NONE;
      if (bus.ex_we_i) begin
         exEff.t = TNEW_NONE;
         exEff.v = bus.ex_vnew_i;
      end
      if (bus.dm_we_i) begin
         dmEff.t = TNEW_NONE;
         dmEff.v = bus.dm_vnew_i;
      end
      rrRecs[0] = exEff;
      rrRecs[1] = dmEff;
      rrRecs[2] = rwEff;
      exRecs[0] = dmEff;
      exRecs[1] = rwEff;
   end

   always_comb begin
      stall = late(exEff, bus.rr_ause0_i, bus.rr_tuse0_i)
            | late(dmEff, bus.rr_ause0_i, bus.rr_tuse0_i)
            | late(exEff, bus.rr_ause1_i, bus.rr_tuse1_i)
            | late(dmEff, bus.rr_ause1_i, bus.rr_tuse1_i);
   end

   // On a stall a bubble enters EX while older producers keep draining.
   always_comb begin
      exEntry_d   = '0;
      exSrc0_d    = '0;
      exSrc1_d    = '0;
      if (!stall) begin
         exEntry_d.a = bus.rr_anew_i;
         exEntry_d.t = sat_dec(bus.rr_tnew_i);
         exEntry_d.v = bus.rr_vnew_i;
         exSrc0_d    = bus.rr_ause0_i;
         exSrc1_d    = bus.rr_ause1_i;
      end
      dmEntry_d.a = exEff.a;
      dmEntry_d.t = sat_dec(exEff.t);
      dmEntry_d.v = exEff.v;
      rwEntry_d.a = dmEff.a;
      rwEntry_d.t = sat_dec(dmEff.t);
      rwEntry_d.v = dmEff.v;
      stallCnt_d  = stallCnt_q;
      if (stall && stallCnt_q != '1) begin
         stallCnt_d = stallCnt_q + CNTW'(1);
      end
   end

   // Asynchronous clear drops any pending stall within the same cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         exEntry_q  <= '0;
         dmEntry_q  <= '0;
         rwEntry_q  <= '0;
         exSrc0_q   <= '0;
         exSrc1_q   <= '0;
         stallCnt_q <= '0;
      end else begin
         exEntry_q  <= exEntry_d;
         dmEntry_q  <= dmEntry_d;
         rwEntry_q  <= rwEntry_d;
         exSrc0_q   <= exSrc0_d;
         exSrc1_q   <= exSrc1_d;
         stallCnt_q <= stallCnt_d;
      end
   end

   fwd_select #(.N(3)) rrSel0 (
      .recs_i(rrRecs), .addr_i(bus.rr_ause0_i), .fallback_i(bus.rr_v0_i),
      .hit_o(selHit[0]), .ready_o(selReady[0]), .value_o(selValue[0])
   );
   fwd_select #(.N(3)) rrSel1 (
      .recs_i(rrRecs), .addr_i(bus.rr_ause1_i), .fallback_i(bus.rr_v1_i),
      .hit_o(selHit[1]), .ready_o(selReady[1]), .value_o(selValue[1])
   );
   fwd_select #(.N(2)) exSel0 (
      .recs_i(exRecs), .addr_i(exSrc0_q), .fallback_i(bus.ex_raw0_i),
      .hit_o(selHit[2]), .ready_o(selReady[2]), .value_o(selValue[2])
   );
   fwd_select #(.N(2)) exSel1 (
      .recs_i(exRecs), .addr_i(exSrc1_q), .fallback_i(bus.ex_raw1_i),
      .hit_o(selHit[3]), .ready_o(selReady[3]), .value_o(selValue[3])
   );

   // A matching producer that is not ready yet hides older values behind it.
   always_comb begin
      bus.stall_o     = stall;
      bus.stall_cnt_o = stallCnt_q;
      bus.rr_opnd0_o  = (selHit[0] && !selReady[0]) ? bus.rr_v0_i   : selValue[0];
      bus.rr_opnd1_o  = (selHit[1] && !selReady[1]) ? bus.rr_v1_i   : selValue[1];
      bus.ex_opnd0_o  = (selHit[2] && !selReady[2]) ? bus.ex_raw0_i : selValue[2];
      bus.ex_opnd1_o  = (selHit[3] && !selReady[3]) ? bus.ex_raw1_i : selValue[3];
   end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed self-checking bench for hazard_forward_unit: forwarding priority,
// load-use stall, register zero, reset during a stall and counter saturation.
module tb_hazard_forward_unit;
   import hazard_pkg::*;

   localparam int CNTW = 4;

   logic clk = 1'b0;
   logic reset;
   int   compared = 0;
   int   mismatched = 0;

   hazard_forward_unit_if #(.CNTW(CNTW)) bus ();

   hazard_forward_unit #(.CNTW(CNTW)) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Drives the RR-side record and clears the EX/DM write-back side.
   task automatic applyStimulus(input logic [AW-1:0] ause0, input logic [TW-1:0] tuse0,
                                input logic [DW-1:0] v0, input logic [AW-1:0] ause1,
                                input logic [TW-1:0] tuse1, input logic [DW-1:0] v1,
                                input logic [AW-1:0] anew, input logic [TW-1:0] tnew,
                                input logic [DW-1:0] vnew);
      bus.rr_ause0_i = ause0;
      bus.rr_tuse0_i = tuse0;
      bus.rr_v0_i    = v0;
      bus.rr_ause1_i = ause1;
      bus.rr_tuse1_i = tuse1;
      bus.rr_v1_i    = v1;
      bus.rr_anew_i  = anew;
      bus.rr_tnew_i  = tnew;
      bus.rr_vnew_i  = vnew;
      bus.ex_we_i    = 1'b0;
      bus.ex_vnew_i  = '0;
      bus.dm_we_i    = 1'b0;
      bus.dm_vnew_i  = '0;
      bus.ex_raw0_i  = '0;
      bus.ex_raw1_i  = '0;
   endtask

   task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                              input logic [DW-1:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic doReset();
      reset = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #2;
      reset = 1'b0;
   endtask

   // Producer $3 with tnew 3, then two cycles of a tuse-0 reader: two stalls.
   task automatic stallGroup();
      applyStimulus(0, 0, 0, 0, 0, 0, 3, 3, 0);
      advance();
      applyStimulus(3, 0, 0, 0, 0, 0, 0, 0, 0);
      advance();
      applyStimulus(3, 0, 0, 0, 0, 0, 0, 0, 0);
      advance();
   endtask

   initial begin
      reset = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      // Empty scoreboard: everything passes through.
      applyStimulus(3, 0, 32'hAAAA, 0, 0, 0, 0, 0, 0);
      bus.ex_raw0_i = 32'hBBBB;
      bus.ex_raw1_i = 32'hCCCC;
      settle();
      checkOutput("reset_stall", 32'(bus.stall_o), 32'd0);
      checkOutput("reset_cnt", 32'(bus.stall_cnt_o), 32'd0);
      checkOutput("reset_rr_opnd0", bus.rr_opnd0_o, 32'hAAAA);
      checkOutput("reset_ex_opnd0", bus.ex_opnd0_o, 32'hBBBB);
      checkOutput("reset_ex_opnd1", bus.ex_opnd1_o, 32'hCCCC);
      advance();

      // add $3 then add $4,$3,$3 with the result arriving from EX.
      doReset();
      applyStimulus(0, 0, 0, 0, 0, 0, 3, 2, 0);
      advance();
      applyStimulus(3, 1, 32'h111, 3, 1, 32'h222, 4, 1, 0);
      bus.ex_we_i   = 1'b1;
      bus.ex_vnew_i = 32'd5;
      settle();
      checkOutput("t1_stall", 32'(bus.stall_o), 32'd0);
      checkOutput("t1_rr_opnd0", bus.rr_opnd0_o, 32'd5);
      checkOutput("t1_rr_opnd1", bus.rr_opnd1_o, 32'd5);
      advance();

      // Load-use: lw $3 then a reader of $3 with tuse 1.
      doReset();
      applyStimulus(0, 0, 0, 0, 0, 0, 3, 3, 0);
      advance();
      applyStimulus(3, 1, 32'h10, 0, 0, 0, 0, 0, 0);
      settle();
      checkOutput("t2_stall", 32'(bus.stall_o), 32'd1);
      checkOutput("t2_blocked_opnd0", bus.rr_opnd0_o, 32'h10);
      advance();
      applyStimulus(3, 1, 32'h10, 0, 0, 0, 0, 0, 0);
      bus.dm_we_i   = 1'b1;
      bus.dm_vnew_i = 32'hCAFE;
      bus.ex_raw0_i = 32'h5678;
      settle();
      checkOutput("t2_no_stall", 32'(bus.stall_o), 32'd0);
      checkOutput("t2_cnt", 32'(bus.stall_cnt_o), 32'd1);
      checkOutput("t2_rr_opnd0", bus.rr_opnd0_o, 32'hCAFE);
      checkOutput("t2_ex_bubble", bus.ex_opnd0_o, 32'h5678);
      advance();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      bus.ex_raw0_i = 32'h1234;
      settle();
      checkOutput("t2_ex_from_w", bus.ex_opnd0_o, 32'hCAFE);
      advance();

      // Register zero never matches and never stalls.
      doReset();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 2, 32'h99);
      advance();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      settle();
      checkOutput("t3_stall", 32'(bus.stall_o), 32'd0);
      advance();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      settle();
      checkOutput("t3_rr_opnd0", bus.rr_opnd0_o, 32'd0);
      advance();

      // E and D both hold $7; E not ready blocks D's stale value.
      doReset();
      applyStimulus(0, 0, 0, 0, 0, 0, 7, 1, 32'hD0);
      advance();
      applyStimulus(0, 0, 0, 0, 0, 0, 7, 2, 0);
      advance();
      applyStimulus(7, 1, 32'h1111, 0, 0, 0, 0, 0, 0);
      settle();
      checkOutput("t4_stall", 32'(bus.stall_o), 32'd0);
      checkOutput("t4_rr_blocked", bus.rr_opnd0_o, 32'h1111);
      advance();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      bus.dm_we_i   = 1'b1;
      bus.dm_vnew_i = 32'h4242;
      bus.ex_raw0_i = 32'h2222;
      settle();
      checkOutput("t4_ex_opnd0", bus.ex_opnd0_o, 32'h4242);
      advance();

      // Reset asserted in the middle of a stalled cycle.
      doReset();
      applyStimulus(0, 0, 0, 0, 0, 0, 3, 3, 0);
      advance();
      applyStimulus(3, 0, 32'h31, 0, 0, 32'h32, 0, 0, 0);
      bus.ex_raw0_i = 32'h41;
      bus.ex_raw1_i = 32'h42;
      settle();
      checkOutput("t5_stall_a", 32'(bus.stall_o), 32'd1);
      advance();
      settle();
      checkOutput("t5_stall_b", 32'(bus.stall_o), 32'd1);
      checkOutput("t5_cnt_before", 32'(bus.stall_cnt_o), 32'd1);
      #1;
      reset = 1'b1;
      #1;
      checkOutput("t5_stall_reset", 32'(bus.stall_o), 32'd0);
      checkOutput("t5_cnt_reset", 32'(bus.stall_cnt_o), 32'd0);
      checkOutput("t5_rr_opnd0", bus.rr_opnd0_o, 32'h31);
      checkOutput("t5_rr_opnd1", bus.rr_opnd1_o, 32'h32);
      checkOutput("t5_ex_opnd0", bus.ex_opnd0_o, 32'h41);
      checkOutput("t5_ex_opnd1", bus.ex_opnd1_o, 32'h42);
      #1;
      reset = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      advance();

      // Stall counter saturation with a 4-bit counter.
      doReset();
      for (int g = 0; g < 7; g++) begin
         stallGroup();
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      settle();
      checkOutput("t6_cnt_14", 32'(bus.stall_cnt_o), 32'd14);
      advance();
      stallGroup();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      settle();
      checkOutput("t6_cnt_sat", 32'(bus.stall_cnt_o), 32'd15);
      advance();
      stallGroup();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      settle();
      checkOutput("t6_cnt_hold", 32'(bus.stall_cnt_o), 32'd15);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
